// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide.
// Optional MDU_EARLY_OUT_EN: trivial cases (div by zero, signed overflow, mul by zero) skip CALC.
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  // state | meaning
  // IDLE  | waiting for a request
  // PREP  | operand magnitudes, sign flags, counter load
  // CALC  | XLEN iterations of shift-add / restoring divide
  // FIX   | sign correction and result select
  // DONE  | response held until consumed
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0]   ZERO     = '0;
  localparam logic [XLEN-1:0]   ONE      = 1;
  localparam logic [XLEN-1:0]   ONES     = '1;
  localparam logic [2*XLEN-1:0] ONE2     = 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);
`ifdef MDU_EARLY_OUT_EN
  localparam logic [XLEN-1:0]   SMIN     = {1'b1, {(XLEN-1){1'b0}}};
`endif

  state_t              state, state_n;
  logic [2:0]          op, op_n;
  logic [XLEN-1:0]     a, a_n, b, b_n, opnd, opnd_n, data, data_n;
  logic [2*XLEN-1:0]   acc, acc_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                neg_q, neg_q_n, neg_r, neg_r_n;

  logic                is_div, a_sgn, b_sgn, a_neg, b_neg, b_nz, div_ge;
  logic [XLEN-1:0]     a_abs, b_abs, div_diff, quot_f, rem_f;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next, div_next, prod_f;

  assign is_div = op[2];
  assign a_sgn  = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
  assign b_sgn  = is_div ? ~op[0] : (op[1:0] == 2'b01);
  assign a_neg  = a_sgn & a[XLEN-1];
  assign b_neg  = b_sgn & b[XLEN-1];
  assign a_abs  = a_neg ? (~a + ONE) : a;
  assign b_abs  = b_neg ? (~b + ONE) : b;
  assign b_nz   = (b != ZERO);

  // Multiply: multiplier sits in the low half and is consumed LSB first.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
  assign mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]}
                           : {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1:1]};

  // Divide: shifted remainder can reach XLEN+1 bits, so compare with the carried-out bit.
  assign div_ge   = (acc[2*XLEN-1:XLEN-1] >= {1'b0, opnd});
  assign div_diff = acc[2*XLEN-2:XLEN-1] - opnd;
  assign div_next = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};

  assign prod_f = neg_q ? (~acc + ONE2) : acc;
  assign quot_f = neg_q ? (~acc[XLEN-1:0] + ONE) : acc[XLEN-1:0];
  assign rem_f  = neg_r ? (~acc[2*XLEN-1:XLEN] + ONE) : acc[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state <= IDLE;
      op    <= '0;
      a     <= '0;
      b     <= '0;
      opnd  <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      data  <= '0;
    end else begin
      state <= state_n;
      op    <= op_n;
      a     <= a_n;
      b     <= b_n;
      opnd  <= opnd_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
      data  <= data_n;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op;
    a_n     = a;
    b_n     = b;
    opnd_n  = opnd;
    acc_n   = acc;
    cnt_n   = cnt;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    data_n  = data;
    case (state)
      IDLE: begin
        if (req_valid) begin
          op_n    = req_op;
          a_n     = req_a;
          b_n     = req_b;
          state_n = PREP;
        end
      end
      PREP: begin
        opnd_n  = is_div ? b_abs : a_abs;
        acc_n   = {ZERO, (is_div ? a_abs : b_abs)};
        neg_q_n = is_div ? ((a_neg ^ b_neg) & b_nz) : (a_neg ^ b_neg);
        neg_r_n = is_div & a_neg;
        cnt_n   = CNT_LAST;
        state_n = CALC;
`ifdef MDU_EARLY_OUT_EN
        if (is_div && !b_nz) begin
          acc_n   = {a_abs, ONES};
          cnt_n   = '0;
          state_n = FIX;
        end else if (is_div && !op[0] && a == SMIN && b == ONES) begin
          acc_n   = {ZERO, SMIN};
          cnt_n   = '0;
          state_n = FIX;
        end else if (!is_div && (a == ZERO || b == ZERO)) begin
          acc_n   = '0;
          cnt_n   = '0;
          state_n = FIX;
        end
`endif
      end
      CALC: begin
        acc_n = is_div ? div_next : mul_next;
        cnt_n = cnt - 1'b1;
        if (cnt == '0) begin
          state_n = FIX;
        end
      end
      FIX: begin
        case (op)
          3'd0:             data_n = prod_f[XLEN-1:0];
          3'd1, 3'd2, 3'd3: data_n = prod_f[2*XLEN-1:XLEN];
          3'd4, 3'd5:       data_n = quot_f;
          default:          data_n = rem_f;
        endcase
        state_n = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign resp_data  = data;

endmodule
